// File: rtl/display_scan_if.sv
// display_scan_if: value/control inputs and scan outputs of the 4-digit display scheduler.
interface display_scan_if;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  brightness;
    logic        lz_blank;
    logic [3:0]  anode_n;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_code;
    logic        dp_n;
    logic        frame_start;
    modport master(output bcd_in, dp_in, load, brightness, lz_blank,
                   input anode_n, digit_idx, digit_code, dp_n, frame_start);
    modport slave(input bcd_in, dp_in, load, brightness, lz_blank,
                  output anode_n, digit_idx, digit_code, dp_n, frame_start);
endinterface

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: 4-digit 7-segment scan with guard phase, PWM brightness,
// leading-zero blanking and frame-synchronous value loading.
module display_scan_scheduler #(
    parameter int CLK_DIV = 16
) (
    input logic clk_in,
    input logic GSR,
    display_scan_if.slave bus
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] GUARD = 2'd0;
    localparam logic [1:0] ON    = 2'd1;
    localparam logic [1:0] OFF   = 2'd2;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]  phase_q, phase_d, lat_q, lat_d, anode_q, anode_d, code_q, code_d, val;
    logic [1:0]  idx_q, idx_d, st;
    logic [15:0] disp_q, disp_d, pbcd_q, pbcd_d;
    logic [3:0]  dpr_q, dpr_d, pdp_q, pdp_d;
    logic        pend_q, pend_d, dp_q, dp_d, fs_q, fs_d;
    logic        tick, wrap, lead, blank, on;
    always_comb begin
        tick    = pre_q == PW'(CLK_DIV - 1);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        wrap    = tick && phase_q == 4'hF && idx_q == 2'd3;
        phase_d = tick ? phase_q + 4'd1 : phase_q;
        idx_d   = (tick && phase_q == 4'hF) ? idx_q + 2'd1 : idx_q;
        pend_d  = bus.load | (pend_q & ~wrap);
        pbcd_d  = bus.load ? bus.bcd_in : pbcd_q;
        pdp_d   = bus.load ? bus.dp_in : pdp_q;
        disp_d  = (wrap && pend_q) ? pbcd_q : disp_q;
        dpr_d   = (wrap && pend_q) ? pdp_q : dpr_q;
        lat_d   = (tick && phase_d == 4'd0) ? bus.brightness : lat_q;
        val     = disp_d[{idx_d, 2'b00} +: 4];
        // A digit is a leading zero when it and every more significant digit are zero
        lead    = bus.lz_blank && (idx_d == 2'd3 ? disp_d[15:12] == 4'd0 :
                                   idx_d == 2'd2 ? disp_d[15:8] == 8'd0 :
                                   idx_d == 2'd1 ? disp_d[15:4] == 12'd0 : 1'b0);
        blank   = val > 4'd9 || lead;
        st      = phase_d == 4'd0 ? GUARD : (phase_d <= lat_d ? ON : OFF);
        on      = st == ON && !blank;
        anode_d = tick ? (on ? ~(4'b0001 << idx_d) : 4'hF) : anode_q;
        code_d  = tick ? (blank ? 4'hF : val) : code_q;
        dp_d    = tick ? ~(on & dpr_d[idx_d]) : dp_q;
        fs_d    = wrap;
    end
    always_ff @(posedge clk_in) begin
        if (GSR) begin
            pre_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            disp_q  <= '0;
            dpr_q   <= '0;
            pbcd_q  <= '0;
            pdp_q   <= '0;
            pend_q  <= 1'b0;
            anode_q <= 4'hF;
            code_q  <= 4'hF;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            disp_q  <= disp_d;
            dpr_q   <= dpr_d;
            pbcd_q  <= pbcd_d;
            pdp_q   <= pdp_d;
            pend_q  <= pend_d;
            anode_q <= anode_d;
            code_q  <= code_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end
    assign bus.anode_n     = anode_q;
    assign bus.digit_idx   = idx_q;
    assign bus.digit_code  = code_q;
    assign bus.dp_n        = dp_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: directed checks of scan order, PWM, blanking, loading and reset at CLK_DIV=4.
module tb_display_scan_scheduler;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int c;
    int cnt;
    always #5 clk = ~clk;
    display_scan_if bus();
    display_scan_scheduler #(.CLK_DIV(4)) dut(.clk_in(clk), .GSR(rst), .bus(bus));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic adv(input int n);
        repeat (n * 4) @(negedge clk);
    endtask
    task automatic sync(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.frame_start && cyc < 400);
        chk("sync", 16'(bus.frame_start), 16'd1);
    endtask
    task automatic ld(input logic [15:0] v, input logic [3:0] d);
        bus.bcd_in = v;
        bus.dp_in = d;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask
    task automatic frame_chk(input string tag, input logic [15:0] codes, input logic [15:0] anodes);
        int cy;
        sync(cy);
        adv(1);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s_code%0d", tag, s), 16'(bus.digit_code), 16'(codes[s*4 +: 4]));
            chk($sformatf("%s_anode%0d", tag, s), 16'(bus.anode_n), 16'(anodes[s*4 +: 4]));
            adv(16);
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.bcd_in = '0;
        bus.dp_in = '0;
        bus.load = 1'b0;
        bus.brightness = 4'd15;
        bus.lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_anode", 16'(bus.anode_n), 16'hF);
        chk("rst_code", 16'(bus.digit_code), 16'hF);
        chk("rst_idx", 16'(bus.digit_idx), 16'd0);
        chk("rst_dp", 16'(bus.dp_n), 16'd1);
        chk("rst_fs", 16'(bus.frame_start), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_tick_code", 16'(bus.digit_code), 16'hF);
        @(negedge clk);
        chk("first_tick_code", 16'(bus.digit_code), 16'h0);
        chk("first_tick_anode", 16'(bus.anode_n), 16'hF);
        ld(16'h1234, 4'b0001);
        sync(c);
        chk("g0_code", 16'(bus.digit_code), 16'h4);
        chk("g0_anode", 16'(bus.anode_n), 16'hF);
        chk("g0_idx", 16'(bus.digit_idx), 16'd0);
        adv(1);
        chk("s0_anode", 16'(bus.anode_n), 16'hE);
        chk("s0_dp", 16'(bus.dp_n), 16'd0);
        adv(14);
        chk("s0p15_anode", 16'(bus.anode_n), 16'hE);
        adv(2);
        chk("s1_code", 16'(bus.digit_code), 16'h3);
        chk("s1_anode", 16'(bus.anode_n), 16'hD);
        chk("s1_dp", 16'(bus.dp_n), 16'd1);
        chk("s1_idx", 16'(bus.digit_idx), 16'd1);
        adv(16);
        chk("s2_code", 16'(bus.digit_code), 16'h2);
        chk("s2_anode", 16'(bus.anode_n), 16'hB);
        adv(16);
        chk("s3_code", 16'(bus.digit_code), 16'h1);
        chk("s3_anode", 16'(bus.anode_n), 16'h7);
        sync(c);
        sync(c);
        chk("frame_period", 16'(c), 16'd256);
        bus.brightness = 4'd4;
        sync(c);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) chk("b4_p4", 16'(bus.anode_n), 16'hE);
            if (i == 5) chk("b4_p5", 16'(bus.anode_n), 16'hF);
            if (bus.anode_n != 4'hF) cnt++;
            adv(1);
        end
        chk("b4_on_ticks", 16'(cnt), 16'd4);
        bus.brightness = 4'd0;
        sync(c);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.anode_n != 4'hF) cnt++;
            adv(1);
        end
        chk("b0_on_ticks", 16'(cnt), 16'd0);
        bus.brightness = 4'd4;
        sync(c);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.anode_n != 4'hF) cnt++;
            if (i == 2) bus.brightness = 4'd12;
            adv(1);
        end
        chk("bchg_cur_slot", 16'(cnt), 16'd4);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.anode_n != 4'hF) cnt++;
            adv(1);
        end
        chk("bchg_next_slot", 16'(cnt), 16'd12);
        bus.brightness = 4'd15;
        bus.lz_blank = 1'b1;
        ld(16'h0070, 4'b0000);
        sync(c);
        frame_chk("lz0070", 16'hFF70, 16'hFFDE);
        ld(16'h0000, 4'b0000);
        sync(c);
        frame_chk("lz0000", 16'hFFF0, 16'hFFFE);
        ld(16'h00A5, 4'b0000);
        sync(c);
        frame_chk("lz00a5", 16'hFFF5, 16'hFFFE);
        bus.lz_blank = 1'b0;
        sync(c);
        adv(18);
        ld(16'h5555, 4'b0000);
        adv(16);
        chk("hold_old_code", 16'(bus.digit_code), 16'h0);
        chk("hold_old_idx", 16'(bus.digit_idx), 16'd2);
        frame_chk("new5555", 16'h5555, 16'h7BDE);
        sync(c);
        adv(5);
        ld(16'h1111, 4'b0000);
        adv(5);
        ld(16'h2222, 4'b0000);
        frame_chk("last_wins", 16'h2222, 16'h7BDE);
        sync(c);
        repeat (255) @(negedge clk);
        bus.bcd_in = 16'h9999;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("wrap_load_fs", 16'(bus.frame_start), 16'd1);
        adv(1);
        chk("wrap_load_old", 16'(bus.digit_code), 16'h2);
        frame_chk("wrap_load_new", 16'h9999, 16'h7BDE);
        sync(c);
        adv(35);
        chk("pre_rst_anode", 16'(bus.anode_n), 16'hB);
        ld(16'h7777, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_anode", 16'(bus.anode_n), 16'hF);
        chk("mid_rst_idx", 16'(bus.digit_idx), 16'd0);
        chk("mid_rst_code", 16'(bus.digit_code), 16'hF);
        sync(c);
        chk("mid_rst_period", 16'(c), 16'd256);
        adv(1);
        chk("pend_dropped_code", 16'(bus.digit_code), 16'h0);
        chk("pend_dropped_anode", 16'(bus.anode_n), 16'hE);
        chk("pend_dropped_dp", 16'(bus.dp_n), 16'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
